// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests and grants.
// Define ARB_HOLD_LIMIT_EN to cap a tenure at HOLD_CYCLES while others wait.
module bus_arbiter #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       m0Req_,
  input  logic       m1Req_,
  input  logic       m2Req_,
  input  logic       m3Req_,
  output logic       m0Grnt_,
  output logic       m1Grnt_,
  output logic       m2Grnt_,
  output logic       m3Grnt_,
  output logic [1:0] owner
);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 2..255");
  end

  logic [3:0] req;
  logic [3:0] grnt;
  logic [1:0] c1;
  logic [1:0] c2;
  logic [1:0] c3;
  logic [1:0] pick;
  logic       found;
  logic       own_req;
  logic       switch_en;
  logic [1:0] owner_nxt;

  assign req = ~{m3Req_, m2Req_, m1Req_, m0Req_};

  assign c1 = owner + 2'd1;
  assign c2 = owner + 2'd2;
  assign c3 = owner + 2'd3;

  assign own_req = req[owner];

  // Search order starts just past the owner, so the owner itself is last.
  always_comb begin
    pick  = owner;
    found = 1'b1;
    priority case (1'b1)
      req[c1]: pick = c1;
      req[c2]: pick = c2;
      req[c3]: pick = c3;
      default: found = 1'b0;
    endcase
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES - 1);

  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       hold_expired;

  assign hold_expired = own_req && (hold_cnt == HOLD_MAX);

  always_comb begin
    switch_en    = found && (!own_req || hold_expired);
    owner_nxt    = switch_en ? pick : owner;
    hold_cnt_nxt = hold_cnt;
    if (switch_en) begin
      hold_cnt_nxt = 8'd0;
    end else if (own_req && hold_cnt != HOLD_MAX) begin
      hold_cnt_nxt = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      owner    <= 2'd0;
      hold_cnt <= 8'd0;
    end else begin
      owner    <= owner_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end
`else
  always_comb begin
    switch_en = found && !own_req;
    owner_nxt = switch_en ? pick : owner;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      owner <= 2'd0;
    end else begin
      owner <= owner_nxt;
    end
  end
`endif

  // Bus is always parked on someone: exactly one grant low.
  assign grnt    = ~(4'b0001 << owner);
  assign m0Grnt_ = grnt[0];
  assign m1Grnt_ = grnt[1];
  assign m2Grnt_ = grnt[2];
  assign m3Grnt_ = grnt[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized + directed bench for bus_arbiter against a rotation model.
// Honors ARB_HOLD_LIMIT_EN with HOLD_CYCLES=4.
module tb_bus_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_;
  logic [3:0] req_n;
  logic       g0;
  logic       g1;
  logic       g2;
  logic       g3;
  logic [1:0] owner;

  int n_cmp = 0;
  int n_bad = 0;
  int m_owner = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .m0Req_ (req_n[0]),
    .m1Req_ (req_n[1]),
    .m2Req_ (req_n[2]),
    .m3Req_ (req_n[3]),
    .m0Grnt_(g0),
    .m1Grnt_(g1),
    .m2Grnt_(g2),
    .m3Grnt_(g3),
    .owner  (owner)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: list waiting masters in rotation order, hand over to the
  // first one when the owner has released (or has used up its tenure).
  task automatic model_edge();
    int  waiting[$];
    bit  own_req;
    bit  forced;
    if (!rst_) begin
      m_owner = 0;
      m_cnt   = 0;
      return;
    end
    for (int k = 1; k < 4; k++) begin
      if (!req_n[(m_owner + k) % 4]) waiting.push_back((m_owner + k) % 4);
    end
    own_req = !req_n[m_owner];
    forced  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    forced  = own_req && (m_cnt == HOLD - 1);
`endif
    if ((!own_req || forced) && waiting.size() > 0) begin
      m_owner = waiting[0];
      m_cnt   = 0;
    end else if (own_req && m_cnt < HOLD - 1) begin
      m_cnt++;
    end
  endtask

  task automatic tick(input string tag);
    logic [3:0] exp_g;
    model_edge();
    @(posedge clk);
    #1;
    exp_g = 4'b1111;
    exp_g[m_owner] = 1'b0;
    chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
    chk({tag, ".grant"}, 32'({g3, g2, g1, g0}), 32'(exp_g));
  endtask

  initial begin
    rst_  = 1'b0;
    req_n = 4'b0000;
    tick("rst0");
    tick("rst1");
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_grant", 32'({g3, g2, g1, g0}), 32'b1110);

    rst_  = 1'b1;
    req_n = 4'b1110;
    tick("post_rst");
    chk("post_rst_owner", 32'(owner), 32'd0);

    req_n = 4'b1011;
    tick("handover");
    chk("handover_owner", 32'(owner), 32'd2);
    chk("handover_grant", 32'({g3, g2, g1, g0}), 32'b1011);

    req_n = 4'b1101;
    tick("to_m1");
    req_n = 4'b0000;
    tick("all_req");
    req_n = 4'b0010;
    tick("rr_2");
    chk("rr_2_owner", 32'(owner), 32'd2);
    req_n = 4'b0110;
    tick("rr_3");
    chk("rr_3_owner", 32'(owner), 32'd3);
    req_n = 4'b1110;
    tick("rr_wrap");
    chk("rr_wrap_owner", 32'(owner), 32'd0);

    req_n = 4'b0111;
    tick("to_m3");
    req_n = 4'b1111;
    tick("park");
    chk("park_owner", 32'(owner), 32'd3);
    chk("park_grant", 32'(g3), 32'd0);
    req_n = 4'b1101;
    tick("unpark");
    chk("unpark_owner", 32'(owner), 32'd1);

    req_n = 4'b1011;
    tick("to_m2");
    tick("hold_m2");
    rst_ = 1'b0;
    tick("mid_rst");
    chk("mid_rst_owner", 32'(owner), 32'd0);
    rst_ = 1'b1;

    req_n = 4'b1100;
    for (int i = 0; i < 110; i++) tick("hold_lim");
`ifndef ARB_HOLD_LIMIT_EN
    chk("no_limit_owner", 32'(owner), 32'd0);
`endif

    req_n = 4'b1111;
    tick("idle");
    req_n = 4'b1110;
    for (int i = 0; i < 40; i++) tick("sole");
    chk("sole_owner", 32'(owner), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst_ = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 3) != 0) req_n = 4'($urandom);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
